// File: rtl/mprj_wb_mailbox_pkg.sv
// Shared register offsets, bit positions and the STATUS layout for the
// Wishbone mailbox.
package mprj_mbox_pkg;

    localparam logic [7:0] MBOX_CTRL    = 8'h00;
    localparam logic [7:0] MBOX_STATUS  = 8'h04;
    localparam logic [7:0] MBOX_TXDATA  = 8'h08;
    localparam logic [7:0] MBOX_RXDATA  = 8'h0C;
    localparam logic [7:0] MBOX_SCRATCH = 8'h10;

    localparam int CTRL_ENABLE     = 0;
    localparam int CTRL_IRQ_RX_EN  = 1;
    localparam int CTRL_IRQ_TXE_EN = 2;
    localparam int CTRL_FLUSH      = 3;

    localparam int STATUS_OVERFLOW    = 24;
    localparam int STATUS_UNDERFLOW   = 25;
    localparam int STATUS_IRQ_PENDING = 26;

    typedef struct packed {
        logic [4:0] rsvd_31_27;
        logic       irq_pending;
        logic       underflow;
        logic       overflow;
        logic [5:0] rsvd_23_18;
        logic       rx_empty;
        logic       tx_full;
        logic [2:0] rsvd_15_13;
        logic [4:0] rx_count;
        logic [2:0] rsvd_7_5;
        logic [4:0] tx_count;
    } mbox_status_t;

endpackage

// File: rtl/mprj_wb_mailbox_if.sv
// Wishbone classic slave bus as seen by the user project window.
interface mprj_wb_mailbox_if;
    logic        wbs_cyc_i;
    logic        wbs_stb_i;
    logic        wbs_we_i;
    logic [3:0]  wbs_sel_i;
    logic [31:0] wbs_adr_i;
    logic [31:0] wbs_dat_i;
    logic        wbs_ack_o;
    logic [31:0] wbs_dat_o;

    modport slave (
        input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
        output wbs_ack_o, wbs_dat_o
    );

    modport master (
        output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
        input  wbs_ack_o, wbs_dat_o
    );
endinterface

// File: rtl/mprj_wb_mailbox_fifo.sv
// First-word-fall-through FIFO with wrap-bit pointers; flush beats push/pop.
module mprj_mbox_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    srst,
    input  logic                    push,
    input  logic [WIDTH-1:0]        push_data,
    input  logic                    pop,
    input  logic                    flush,
    output logic                    full,
    output logic                    empty,
    output logic [$clog2(DEPTH):0]  count,
    output logic [WIDTH-1:0]        head
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr_reg, wr_ptr_next;
    logic [AW:0]      rd_ptr_reg, rd_ptr_next;
    logic [WIDTH-1:0] mem_reg [DEPTH];
    logic             push_ok, pop_ok;

    assign empty   = (wr_ptr_reg == rd_ptr_reg);
    assign full    = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                     (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
    assign count   = wr_ptr_reg - rd_ptr_reg;
    assign head    = mem_reg[rd_ptr_reg[AW-1:0]];
    // Full is judged before any same-cycle pop, so a full FIFO refuses pushes.
    assign push_ok = push & ~full;
    assign pop_ok  = pop & ~empty;

    always_comb begin
        wr_ptr_next = wr_ptr_reg;
        rd_ptr_next = rd_ptr_reg;
        if (flush) begin
            wr_ptr_next = '0;
            rd_ptr_next = '0;
        end else begin
            if (push_ok) wr_ptr_next = wr_ptr_reg + 1'b1;
            if (pop_ok)  rd_ptr_next = rd_ptr_reg + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            wr_ptr_reg <= wr_ptr_next;
            rd_ptr_reg <= rd_ptr_next;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem_reg[wr_ptr_reg[AW-1:0]] <= push_data;
    end
endmodule

// File: rtl/mprj_wb_mailbox.sv
// Wishbone mailbox: CPU<->user FIFOs, control/status/scratch registers.
// Define MBOX_IRQ_EN to build the interrupt logic and CTRL[2:1]/STATUS[26].
module mprj_wb_mailbox
    import mprj_mbox_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
    parameter int          DEPTH     = 8
) (
    input  logic                wb_clk_i,
    input  logic                wb_rst_i,
    mprj_wb_mailbox_if.slave    wbs,
    output logic [31:0]         usr_tx_tdata,
    output logic                usr_tx_tvalid,
    input  logic                usr_tx_tready,
    input  logic [31:0]         usr_rx_tdata,
    input  logic                usr_rx_tvalid,
    output logic                usr_rx_tready,
    output logic                user_irq
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic          ack_reg;
    logic [31:0]   dat_reg;
    logic          enable_reg;
    logic          overflow_reg, underflow_reg;
    logic [31:0]   scratch_reg, scratch_next;
    logic          irq_rx_en, irq_txe_en, irq_pending;

    logic          accept, wr_acc, rd_acc;
    logic [7:0]    off;
    logic          ctrl_wr, status_wr, scratch_wr, flush;
    logic          tx_push, tx_pop, rx_push, rx_pop;
    logic          tx_full, tx_empty, rx_full, rx_empty;
    logic [CW-1:0] tx_count, rx_count;
    logic [31:0]   tx_head, rx_head;
    logic [31:0]   rd_data;
    mbox_status_t  status;

    assign off    = wbs.wbs_adr_i[7:0];
    assign accept = wbs.wbs_cyc_i & wbs.wbs_stb_i & ~ack_reg &
                    (wbs.wbs_adr_i[31:8] == BASE_ADDR[31:8]);
    assign wr_acc = accept & wbs.wbs_we_i;
    assign rd_acc = accept & ~wbs.wbs_we_i;

    assign ctrl_wr    = wr_acc && (off == MBOX_CTRL) && wbs.wbs_sel_i[0];
    assign status_wr  = wr_acc && (off == MBOX_STATUS) && wbs.wbs_sel_i[3];
    assign scratch_wr = wr_acc && (off == MBOX_SCRATCH);
    assign flush      = ctrl_wr & wbs.wbs_dat_i[CTRL_FLUSH];
    assign tx_push    = wr_acc && (off == MBOX_TXDATA) && (|wbs.wbs_sel_i);
    assign rx_pop     = rd_acc && (off == MBOX_RXDATA);

    assign usr_tx_tvalid = enable_reg & ~tx_empty;
    assign usr_tx_tdata  = tx_head;
    assign usr_rx_tready = enable_reg & ~rx_full;
    assign tx_pop        = usr_tx_tvalid & usr_tx_tready;
    assign rx_push       = usr_rx_tvalid & usr_rx_tready;

    mprj_mbox_fifo #(.DEPTH(DEPTH), .WIDTH(32)) u_tx_fifo (
        .clk       (wb_clk_i),
        .srst      (wb_rst_i),
        .push      (tx_push),
        .push_data (wbs.wbs_dat_i),
        .pop       (tx_pop),
        .flush     (flush),
        .full      (tx_full),
        .empty     (tx_empty),
        .count     (tx_count),
        .head      (tx_head)
    );

    mprj_mbox_fifo #(.DEPTH(DEPTH), .WIDTH(32)) u_rx_fifo (
        .clk       (wb_clk_i),
        .srst      (wb_rst_i),
        .push      (rx_push),
        .push_data (usr_rx_tdata),
        .pop       (rx_pop),
        .flush     (flush),
        .full      (rx_full),
        .empty     (rx_empty),
        .count     (rx_count),
        .head      (rx_head)
    );

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_scratch_byte
            assign scratch_next[8*gi +: 8] = (scratch_wr && wbs.wbs_sel_i[gi]) ?
                                             wbs.wbs_dat_i[8*gi +: 8] :
                                             scratch_reg[8*gi +: 8];
        end
    endgenerate

    always_comb begin
        status             = '0;
        status.tx_count    = 5'(tx_count);
        status.rx_count    = 5'(rx_count);
        status.tx_full     = tx_full;
        status.rx_empty    = rx_empty;
        status.overflow    = overflow_reg;
        status.underflow   = underflow_reg;
        status.irq_pending = irq_pending;
    end

    always_comb begin
        rd_data = '0;
        case (off)
            MBOX_CTRL:    rd_data = {28'd0, 1'b0, irq_txe_en, irq_rx_en, enable_reg};
            MBOX_STATUS:  rd_data = status;
            MBOX_RXDATA:  rd_data = rx_empty ? 32'd0 : rx_head;
            MBOX_SCRATCH: rd_data = scratch_reg;
            default:      rd_data = '0;
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            ack_reg       <= 1'b0;
            dat_reg       <= '0;
            enable_reg    <= 1'b0;
            overflow_reg  <= 1'b0;
            underflow_reg <= 1'b0;
            scratch_reg   <= '0;
        end else begin
            ack_reg     <= accept;
            // Data bus is forced to zero outside read acks.
            dat_reg     <= rd_acc ? rd_data : 32'd0;
            scratch_reg <= scratch_next;
            if (ctrl_wr) enable_reg <= wbs.wbs_dat_i[CTRL_ENABLE];
            if (tx_push && tx_full)
                overflow_reg <= 1'b1;
            else if (status_wr && wbs.wbs_dat_i[STATUS_OVERFLOW])
                overflow_reg <= 1'b0;
            if (rx_pop && rx_empty)
                underflow_reg <= 1'b1;
            else if (status_wr && wbs.wbs_dat_i[STATUS_UNDERFLOW])
                underflow_reg <= 1'b0;
        end
    end

`ifdef MBOX_IRQ_EN
    logic irq_rx_en_reg, irq_txe_en_reg, irq_reg;

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            irq_rx_en_reg  <= 1'b0;
            irq_txe_en_reg <= 1'b0;
            irq_reg        <= 1'b0;
        end else begin
            if (ctrl_wr) begin
                irq_rx_en_reg  <= wbs.wbs_dat_i[CTRL_IRQ_RX_EN];
                irq_txe_en_reg <= wbs.wbs_dat_i[CTRL_IRQ_TXE_EN];
            end
            irq_reg <= (irq_rx_en_reg & ~rx_empty) | (irq_txe_en_reg & tx_empty);
        end
    end

    assign irq_rx_en   = irq_rx_en_reg;
    assign irq_txe_en  = irq_txe_en_reg;
    assign irq_pending = irq_reg;
`else
    assign irq_rx_en   = 1'b0;
    assign irq_txe_en  = 1'b0;
    assign irq_pending = 1'b0;
`endif

    assign user_irq      = irq_pending;
    assign wbs.wbs_ack_o = ack_reg;
    assign wbs.wbs_dat_o = dat_reg;
endmodule
